// File: rtl/bigseg_index_engine.sv
// bigseg_index_engine: two-stage lookup pipeline that turns a segment index
// plus packet tuple into per-group table indices. Big segments read a
// per-segment table entry and either take the stored index or hash the group
// key. Small segments pass through as all-zero results.
// Optional feature macro: BIGSEG_WR_BYPASS_EN. When it is defined, a lookup
// accepted in the same cycle as a write to the same valid address sees the
// data being written.
module bigseg_index_engine #(
  parameter int unsigned GROUP_NUM          = 4,
  parameter int unsigned INDEX_BIT_LEN      = 11,
  parameter int unsigned KEY_BIT_LEN        = 32,
  parameter int unsigned PACKET_BIT_LEN     = 128,
  parameter int unsigned BIGSEGMENT_NUM     = 184,
  parameter int unsigned BIGSEGMENT_BIT_LEN = 8,
  localparam int unsigned ENTRY_BIT_LEN     = (INDEX_BIT_LEN + 1) * (GROUP_NUM + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PACKET_BIT_LEN-1:0]          tupleData,
  input  logic                               smallorbig_segment,
  input  logic [INDEX_BIT_LEN-1:0]           segment_index,
  input  logic                               wr_en,
  input  logic [BIGSEGMENT_BIT_LEN-1:0]      wr_addr,
  input  logic [ENTRY_BIT_LEN-1:0]           wr_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_bigseg,
  output logic [GROUP_NUM*INDEX_BIT_LEN-1:0] out_group_index,
  output logic [INDEX_BIT_LEN-1:0]           out_last_table_index,
  output logic                               out_last_smallorbiggroup,
  output logic                               out_addr_err
);

  localparam int unsigned FIELD_LEN  = INDEX_BIT_LEN + 1;
  localparam int unsigned KEYS_LEN   = GROUP_NUM * KEY_BIT_LEN;
  localparam int unsigned HASH_SHIFT = 32 - INDEX_BIT_LEN;
  localparam logic [31:0] HASH_MULT  = 32'h8000_8001;

  logic [ENTRY_BIT_LEN-1:0] table_mem [BIGSEGMENT_NUM];

  logic                               s1_full;
  logic                               s1_big;
  logic                               s1_err;
  logic [ENTRY_BIT_LEN-1:0]           s1_entry;
  logic [KEYS_LEN-1:0]                s1_keys;

  logic                               s2_advance;
  logic                               accept;
  logic [BIGSEGMENT_BIT_LEN-1:0]      rd_addr;
  logic                               rd_addr_ok;
  logic                               wr_addr_ok;
  logic [ENTRY_BIT_LEN-1:0]           lookup_entry_c;
  logic [FIELD_LEN-1:0]               field_c;
  logic [GROUP_NUM*INDEX_BIT_LEN-1:0] grp_c;
  logic                               unused_bits;

  // Multiplicative hash: low 32 bits of key*0x80008001, top INDEX_BIT_LEN bits kept.
  function automatic logic [INDEX_BIT_LEN-1:0] hash_key(input logic [KEY_BIT_LEN-1:0] key);
    logic [31:0] prod;
    prod = 32'(key) * HASH_MULT;
    return INDEX_BIT_LEN'(prod >> HASH_SHIFT);
  endfunction

  // Handshake and address qualification.
  assign s2_advance  = !out_valid || out_ready;
  assign in_ready    = !s1_full || s2_advance;
  assign accept      = in_valid && in_ready;
  assign rd_addr     = segment_index[BIGSEGMENT_BIT_LEN-1:0];
  assign rd_addr_ok  = 32'(rd_addr) < BIGSEGMENT_NUM;
  assign wr_addr_ok  = 32'(wr_addr) < BIGSEGMENT_NUM;
  assign unused_bits = ^{segment_index, tupleData};

  // Table write port; out-of-range addresses are dropped, contents never reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_addr_ok) begin
      table_mem[wr_addr] <= wr_data;
    end
  end

  // Entry seen by a lookup: zero for small segments and bad addresses.
  always_comb begin
    lookup_entry_c = '0;
    if (smallorbig_segment && rd_addr_ok) begin
      lookup_entry_c = table_mem[rd_addr];
`ifdef BIGSEG_WR_BYPASS_EN
      if (wr_en && wr_addr_ok && (wr_addr == rd_addr)) begin
        lookup_entry_c = wr_data;
      end
`endif
    end
  end

  // Stage 1: capture entry, keys and flags on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_full  <= 1'b0;
      s1_big   <= 1'b0;
      s1_err   <= 1'b0;
      s1_entry <= '0;
      s1_keys  <= '0;
    end else if (accept) begin
      s1_full  <= 1'b1;
      s1_big   <= smallorbig_segment;
      s1_err   <= smallorbig_segment && !rd_addr_ok;
      s1_entry <= lookup_entry_c;
      s1_keys  <= tupleData[KEYS_LEN-1:0];
    end else if (s2_advance) begin
      s1_full  <= 1'b0;
    end
  end

  // Per-group index select: hash when the entry flag is set, else stored index.
  always_comb begin
    grp_c   = '0;
    field_c = '0;
    for (int unsigned g = 0; g < GROUP_NUM; g++) begin
      field_c = s1_entry[ENTRY_BIT_LEN-1-g*FIELD_LEN -: FIELD_LEN];
      if (s1_big) begin
        grp_c[g*INDEX_BIT_LEN +: INDEX_BIT_LEN] =
          field_c[0] ? hash_key(s1_keys[g*KEY_BIT_LEN +: KEY_BIT_LEN])
                     : field_c[FIELD_LEN-1:1];
      end
    end
  end

  // Stage 2: registered result, held stable while out_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid                <= 1'b0;
      out_bigseg               <= 1'b0;
      out_group_index          <= '0;
      out_last_table_index     <= '0;
      out_last_smallorbiggroup <= 1'b0;
      out_addr_err             <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_full;
      if (s1_full) begin
        out_bigseg               <= s1_big;
        out_group_index          <= grp_c;
        out_last_table_index     <= s1_entry[INDEX_BIT_LEN:1];
        out_last_smallorbiggroup <= s1_entry[0];
        out_addr_err             <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_bigseg_index_engine.sv
// Scoreboard bench for bigseg_index_engine: directed corner cases followed by
// randomized traffic, checked against a behavioural table/hash model.
module tb_bigseg_index_engine;

  localparam int GN  = 4;
  localparam int IW  = 11;
  localparam int KW  = 32;
  localparam int PW  = 128;
  localparam int NUM = 184;
  localparam int AW  = 8;
  localparam int FL  = IW + 1;
  localparam int EW  = FL * (GN + 1);

  typedef struct packed {
    logic          big;
    logic [GN*IW-1:0] grp;
    logic [IW-1:0] lti;
    logic          lsg;
    logic          err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    tupleData;
  logic             smallorbig_segment;
  logic [IW-1:0]    segment_index;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [EW-1:0]    wr_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_bigseg;
  logic [GN*IW-1:0] out_group_index;
  logic [IW-1:0]    out_last_table_index;
  logic             out_last_smallorbiggroup;
  logic             out_addr_err;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [EW-1:0] mdl [NUM];

  bigseg_index_engine dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .tupleData                (tupleData),
    .smallorbig_segment       (smallorbig_segment),
    .segment_index            (segment_index),
    .wr_en                    (wr_en),
    .wr_addr                  (wr_addr),
    .wr_data                  (wr_data),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .out_bigseg               (out_bigseg),
    .out_group_index          (out_group_index),
    .out_last_table_index     (out_last_table_index),
    .out_last_smallorbiggroup (out_last_smallorbiggroup),
    .out_addr_err             (out_addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mhash(input logic [31:0] k);
    logic [31:0] p;
    p = k * 32'h8000_8001;
    return p[31:32-IW];
  endfunction

  // Reference lookup from the table model as it stands before this cycle's write.
  function automatic exp_t model(input logic [PW-1:0] td, input logic big,
                                 input logic [IW-1:0] idx, input logic we,
                                 input logic [AW-1:0] wa, input logic [EW-1:0] wd);
    exp_t r;
    logic [EW-1:0] e;
    logic [FL-1:0] f;
    int a;
    r = '0;
    e = '0;
    a = int'(idx[AW-1:0]);
    if (big) begin
      r.big = 1'b1;
      if (a >= NUM) begin
        r.err = 1'b1;
      end else begin
        e = mdl[a];
`ifdef BIGSEG_WR_BYPASS_EN
        if (we && int'(wa) == a) e = wd;
`endif
      end
      for (int g = 0; g < GN; g++) begin
        f = e[EW-1-g*FL -: FL];
        r.grp[g*IW +: IW] = f[0] ? mhash(td[g*KW +: KW]) : f[FL-1:1];
      end
      r.lti = e[IW:1];
      r.lsg = e[0];
    end
    return r;
  endfunction

  function automatic logic [EW-1:0] rand_entry();
    return EW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [PW-1:0] rand_tuple();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %h need %h", name, got, need);
    end
  endtask

  // One clock of stimulus; pushes the expected result when the request is accepted.
  task automatic cyc(input logic iv, input logic [PW-1:0] td, input logic big,
                     input logic [IW-1:0] idx, input logic we, input logic [AW-1:0] wa,
                     input logic [EW-1:0] wd, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = iv; tupleData = td; smallorbig_segment = big; segment_index = idx;
    wr_en = we; wr_addr = wa; wr_data = wd; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (acc) sb.push_back(model(td, big, idx, we, wa, wd));
    if (we && int'(wa) < NUM) mdl[wa] = wd;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, ordy, a);
  endtask

  task automatic lookup(input logic [PW-1:0] td, input logic big, input logic [IW-1:0] idx);
    logic a;
    int n;
    n = 0;
    a = 1'b0;
    while (!a && n < 10) begin
      cyc(1'b1, td, big, idx, 1'b0, '0, '0, 1'b1, a);
      n++;
    end
    if (!a) check("lookup_accept_timeout", 64'(a), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      idle(1'b1);
      n++;
    end
    idle(1'b1);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops on every transfer and checks stability while stalled.
  initial begin : monitor
    logic held;
    exp_t hold_v, got, e;
    held = 1'b0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        got = {out_bigseg, out_group_index, out_last_table_index,
               out_last_smallorbiggroup, out_addr_err};
        if (held) begin
          total++;
          if (!out_valid || got !== hold_v) begin
            bad++;
            $display("FAIL hold_stable: got valid=%0b %h need valid=1 %h", out_valid, got, hold_v);
          end
        end
        held = out_valid && !out_ready;
        hold_v = got;
        if (out_valid && out_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL result_unexpected: got %h need no output", got);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL result: got %h need %h", got, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout need completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic a, a1, a2, a3;
    logic [EW-1:0] e, e_old, e_new;
    logic [PW-1:0] td;
    logic [IW-1:0] idx;
    logic [AW-1:0] wa;
    int nacc;

    rst = 1'b1; in_valid = 1'b0; tupleData = '0; smallorbig_segment = 1'b0;
    segment_index = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
    for (int i = 0; i < NUM; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'({out_bigseg, out_last_table_index, out_addr_err}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Fill the whole table with random entries.
    for (int i = 0; i < NUM; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, AW'(i), rand_entry(), 1'b1, a);

    // Stored index for group0, hashed groups 1..3.
    e = '0;
    e[EW-1 -: FL] = {11'h123, 1'b0};
    for (int g = 1; g < GN; g++) e[EW-1-g*FL -: FL] = {IW'($urandom()), 1'b1};
    e[IW:0] = {11'h2AB, 1'b1};
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 8'd5, e, 1'b1, a);
    td = rand_tuple();
    td[31:0] = 32'h0000_0001;
    lookup(td, 1'b1, 11'd5);
    td[63:32] = 32'h0000_0001;
    td[95:64] = 32'hFFFF_FFFF;
    lookup(td, 1'b1, 11'h405);
    drain();

    // Backpressure: three requests against a stalled output.
    td = rand_tuple();
    cyc(1'b1, td, 1'b1, 11'd9, 1'b0, '0, '0, 1'b0, a1);
    cyc(1'b1, td ^ 128'h1, 1'b1, 11'd10, 1'b0, '0, '0, 1'b0, a2);
    cyc(1'b1, td ^ 128'h2, 1'b1, 11'd11, 1'b0, '0, '0, 1'b0, a3);
    nacc = int'(a1) + int'(a2) + int'(a3);
    check("stall_accepts", 64'(nacc), 64'd2);
    check("stall_ready_low", 64'(in_ready), 64'd0);
    lookup(td ^ 128'h2, 1'b1, 11'd11);
    drain();

    // Same-cycle write and lookup at address 7.
    e_old = rand_entry();
    e_new = rand_entry();
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 8'd7, e_old, 1'b1, a);
    cyc(1'b1, rand_tuple(), 1'b1, 11'd7, 1'b1, 8'd7, e_new, 1'b1, a);
    check("bypass_accept", 64'(a), 64'd1);
    lookup(rand_tuple(), 1'b1, 11'd7);
    drain();

    // Out-of-range address: lookup reports error, write is dropped.
    lookup(rand_tuple(), 1'b1, 11'd200);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 8'd200, {EW{1'b1}}, 1'b1, a);
    lookup(rand_tuple(), 1'b1, 11'd200);
    lookup(rand_tuple(), 1'b1, 11'd16);
    lookup(rand_tuple(), 1'b1, 11'd183);
    lookup(rand_tuple(), 1'b1, 11'd184);
    lookup(rand_tuple(), 1'b0, 11'd5);
    drain();

    // Reset with both stages occupied.
    cyc(1'b1, rand_tuple(), 1'b1, 11'd3, 1'b0, '0, '0, 1'b0, a);
    cyc(1'b1, rand_tuple(), 1'b1, 11'd4, 1'b0, '0, '0, 1'b0, a);
    idle(1'b0);
    check("full_before_reset", 64'({out_valid, in_ready}), 64'b10);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_kills_valid", 64'(out_valid), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset2", 64'(in_ready), 64'd1);
    repeat (4) idle(1'b1);
    check("no_stale_result", 64'(out_valid), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      idx = IW'($urandom());
      if ($urandom_range(0, 7) != 0) idx[AW-1:0] = AW'($urandom_range(0, NUM - 1));
      wa = ($urandom_range(0, 3) == 0) ? idx[AW-1:0] : AW'($urandom());
      td = rand_tuple();
      if ($urandom_range(0, 7) == 0) td[KW-1:0] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h1;
      cyc($urandom_range(0, 3) != 0, td, $urandom_range(0, 3) != 0, idx,
          $urandom_range(0, 2) == 0, wa, rand_entry(), $urandom_range(0, 3) != 0, a);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bigseg_index_engine.md
BIGSEG_INDEX_ENGINE -- requirements
Module: bigseg_index_engine

Interface
REQ-001 SHALL have parameter GROUP_NUM, default 4: number of hashable groups; the protocol group is carried extra.
REQ-002 SHALL have parameter INDEX_BIT_LEN, default 11: width of a group index.
REQ-003 SHALL have parameter KEY_BIT_LEN, default 32: hash key width per group.
REQ-004 SHALL have parameter PACKET_BIT_LEN, default 128, constrained to >= GROUP_NUM*KEY_BIT_LEN: tuple width.
REQ-005 SHALL have parameter BIGSEGMENT_NUM, default 184: table depth.
REQ-006 SHALL have parameter BIGSEGMENT_BIT_LEN, default 8: table address width.
REQ-007 SHALL have derived localparam ENTRY_BIT_LEN = (INDEX_BIT_LEN+1)*(GROUP_NUM+1).
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 in_valid / in_ready  in / out  1 / 1  lookup request handshake.
REQ-011 tupleData  in  PACKET_BIT_LEN  packet header fields.
REQ-012 smallorbig_segment  in  1  1 = big segment (table lookup), 0 = small (pass-through).
REQ-013 segment_index  in  INDEX_BIT_LEN  segment index; low BIGSEGMENT_BIT_LEN bits address the table.
REQ-014 wr_en, wr_addr, wr_data  in  1, BIGSEGMENT_BIT_LEN, ENTRY_BIT_LEN  table update port, independent of lookup.
REQ-015 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-016 out_bigseg  out  1  registered copy of smallorbig_segment.
REQ-017 out_group_index  out  GROUP_NUM*INDEX_BIT_LEN  group g index in slice [g*INDEX_BIT_LEN +: INDEX_BIT_LEN].
REQ-018 out_last_table_index, out_last_smallorbiggroup  out  INDEX_BIT_LEN, 1  protocol group passthrough.
REQ-019 out_addr_err  out  1  lookup address >= BIGSEGMENT_NUM.

Function
REQ-020 Entry layout: group g field = entry[ENTRY_BIT_LEN-1-g*(INDEX_BIT_LEN+1) -: INDEX_BIT_LEN+1] = {index, big_flag}; protocol field = entry[INDEX_BIT_LEN:0] = {table_index, flag}.
REQ-021 Two-stage pipeline: S1 captures table entry, keys and flags on in_valid&&in_ready; S2 computes the outputs; latency is exactly 2 cycles with no stall.
REQ-022 in_ready = !s1_full || s2_advance, where s2_advance = !out_valid || out_ready; out_valid holds with all outputs stable until out_ready.
REQ-023 Key g = tupleData[g*KEY_BIT_LEN +: KEY_BIT_LEN], zero-extended to 32 bits.
REQ-024 Hash = ((key*32'h80008001) mod 2^32) >> (32-INDEX_BIT_LEN); product truncated to 32 bits before the shift.
REQ-025 Big segment: group g index = hash if big_flag=1, else stored index; protocol fields come from the entry.
REQ-026 Small segment: all index outputs = 0, out_bigseg = 0, out_addr_err = 0; the table is not read.
REQ-027 Address >= BIGSEGMENT_NUM on a big lookup: entry treated as all-zero, so all group indices are 0 with no hashing, and out_addr_err = 1.
REQ-028 Write commits at the clock edge; wr_addr >= BIGSEGMENT_NUM is ignored.
REQ-029 Entry is sampled at S1 accept; later writes do not alter in-flight results.
REQ-030 Back-to-back accepts sustain 1 result/cycle while out_ready = 1.

Reset
REQ-031 rst clears s1_full, out_valid and all outputs to 0 immediately, and aborts in-flight lookups without emitting them.
REQ-032 Table contents are not reset; the simulation initial value is all-zero.
REQ-033 in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-034 Macro BIGSEG_WR_BYPASS_EN defined: a lookup accepted in the same cycle as a write to the same valid address uses wr_data.
REQ-035 Macro BIGSEG_WR_BYPASS_EN undefined: that lookup uses the pre-write entry.

Verification
REQ-036 Write addr 5 with group0 = {11'h123, 0}, others flag = 1; lookup addr 5 with key0 = 0x00000001 -> after 2 cycles group0 = 0x123 and group1 = hash(key1).
REQ-037 Key = 0x00000001, flag = 1 -> index = 0x80008001 >> 21 = 0x400; key = 0xFFFFFFFF -> product mod 2^32 = 0x7FFF7FFF -> 0x3FF.
REQ-038 Hold out_ready = 0 for 3 cycles with 3 requests issued -> in_ready drops after 2 accepts, outputs stay stable, and no result is lost or duplicated on release.
REQ-039 Same-cycle write and lookup to addr 7 -> new data with BIGSEG_WR_BYPASS_EN, old data without it.
REQ-040 Lookup addr 200 with depth 184 -> out_addr_err = 1 and indices 0; write to addr 200 leaves all entries unchanged.
REQ-041 Assert rst while both stages are full -> out_valid = 0 in the same cycle and no stale result appears after release.
